// File: rtl/btb_assoc_queued.sv
// Set-associative branch target buffer with an in-order update queue,
// true-LRU replacement and a set-by-set flush sequencer.
//
// Handshake: an update lane is accepted only in a cycle where upd_ready is
// high and flush_req is low; upd_ready depends on registered state only, so
// lanes offered while it is low are discarded without back-pressure.
module btb_assoc_queued #(
   parameter int N_RD        = 2,
   parameter int N_WR        = 2,
   parameter int NUM_SETS    = 16,
   parameter int NUM_WAYS    = 4,
   parameter int OFFSET_BITS = 2,
   parameter int TAG_BITS    = 8,
   parameter int UPD_DEPTH   = 4,
   parameter int ADDR_BITS   = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_RD*ADDR_BITS-1:0]   rd_PCs,
   output logic [N_RD*ADDR_BITS-1:0]   rd_targets,
   output logic [N_RD-1:0]             rd_hits,
   input  logic [N_WR-1:0]             upd_valid,
   input  logic [N_WR*ADDR_BITS-1:0]   upd_branch_PC,
   input  logic [N_WR*ADDR_BITS-1:0]   upd_target_PC,
   output logic                        upd_ready,
   input  logic                        flush_req,
   output logic                        flush_busy,
   output logic                        dbg_state
);

   localparam int SET_W   = $clog2(NUM_SETS);
   localparam int WAY_W   = $clog2(NUM_WAYS);
   localparam int PTR_W   = $clog2(UPD_DEPTH);
   localparam int CNT_W   = $clog2(UPD_DEPTH + 1);

   typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [SET_W-1:0]       fcnt_q, fcnt_d;
   logic                   valid_q [NUM_SETS][NUM_WAYS];
   logic                   valid_d [NUM_SETS][NUM_WAYS];
   logic [TAG_BITS-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
   logic [TAG_BITS-1:0]    tag_d   [NUM_SETS][NUM_WAYS];
   logic [ADDR_BITS-1:0]   tgt_q   [NUM_SETS][NUM_WAYS];
   logic [ADDR_BITS-1:0]   tgt_d   [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0]       age_q   [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0]       age_d   [NUM_SETS][NUM_WAYS];
   logic [ADDR_BITS-1:0]   qpc_q   [UPD_DEPTH];
   logic [ADDR_BITS-1:0]   qpc_d   [UPD_DEPTH];
   logic [ADDR_BITS-1:0]   qtgt_q  [UPD_DEPTH];
   logic [ADDR_BITS-1:0]   qtgt_d  [UPD_DEPTH];
   logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d, wp;
   logic [CNT_W-1:0]       count_q, count_d, enq_n;

   // drain-path scratch
   logic                   drain, hit_f, inv_f;
   logic [SET_W-1:0]       d_set;
   logic [TAG_BITS-1:0]    d_tag;
   logic [WAY_W-1:0]       hit_w, inv_w, lru_w, sel_w, old_age;

   // PC bits outside the set/tag fields carry no information for this table
   logic unused_pc_bits;
   assign unused_pc_bits = ^{rd_PCs, upd_branch_PC};

   function automatic logic [SET_W-1:0] pc_set(input logic [ADDR_BITS-1:0] pc);
      return pc[OFFSET_BITS +: SET_W];
   endfunction

   function automatic logic [TAG_BITS-1:0] pc_tag(input logic [ADDR_BITS-1:0] pc);
      return pc[OFFSET_BITS+SET_W +: TAG_BITS];
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(UPD_DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Readiness ignores this cycle's dequeue on purpose: it must not depend on drain timing
   assign upd_ready  = (state_q == S_IDLE) &&
                       ((CNT_W'(UPD_DEPTH) - count_q) >= CNT_W'(N_WR));
   assign flush_busy = (state_q == S_FLUSH);
   assign dbg_state  = state_q;

   // Next-state: flush sequencing, queue enqueue, head drain with LRU way choice
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      age_d   = age_q;
      qpc_d   = qpc_q;
      qtgt_d  = qtgt_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      wp      = tail_q;
      enq_n   = '0;
      drain   = 1'b0;
      d_set   = pc_set(qpc_q[head_q]);
      d_tag   = pc_tag(qpc_q[head_q]);
      hit_f   = 1'b0;
      inv_f   = 1'b0;
      hit_w   = '0;
      inv_w   = '0;
      lru_w   = '0;
      sel_w   = '0;
      old_age = '0;
      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               // flush wins over this cycle's updates and drain; queue is discarded
               state_d = S_FLUSH;
               fcnt_d  = '0;
               count_d = '0;
               head_d  = '0;
               tail_d  = '0;
            end else begin
               if (upd_ready) begin
                  for (int l = 0; l < N_WR; l++) begin
                     if (upd_valid[l]) begin
                        qpc_d[wp]  = upd_branch_PC[l*ADDR_BITS +: ADDR_BITS];
                        qtgt_d[wp] = upd_target_PC[l*ADDR_BITS +: ADDR_BITS];
                        wp         = ptr_inc(wp);
                        enq_n      = enq_n + CNT_W'(1);
                     end
                  end
                  tail_d = wp;
               end
               if (count_q != '0) begin
                  drain  = 1'b1;
                  head_d = ptr_inc(head_q);
                  for (int w = 0; w < NUM_WAYS; w++) begin
                     if (valid_q[d_set][w] && (tag_q[d_set][w] == d_tag) && !hit_f) begin
                        hit_f = 1'b1;
                        hit_w = WAY_W'(w);
                     end
                     if (!valid_q[d_set][w] && !inv_f) begin
                        inv_f = 1'b1;
                        inv_w = WAY_W'(w);
                     end
                     if (valid_q[d_set][w] && (age_q[d_set][w] == '0))
                        lru_w = WAY_W'(w);
                  end
                  sel_w   = hit_f ? hit_w : (inv_f ? inv_w : lru_w);
                  old_age = age_q[d_set][sel_w];
                  for (int w = 0; w < NUM_WAYS; w++) begin
                     if (WAY_W'(w) == sel_w) begin
                        valid_d[d_set][w] = 1'b1;
                        tag_d[d_set][w]   = d_tag;
                        tgt_d[d_set][w]   = qtgt_q[head_q];
                        age_d[d_set][w]   = WAY_W'(NUM_WAYS-1);
                     end else if (valid_q[d_set][w]) begin
                        if (hit_f || !inv_f) begin
                           if (age_q[d_set][w] > old_age)
                              age_d[d_set][w] = age_q[d_set][w] - 1'b1;
                        end else if (age_q[d_set][w] != '0) begin
                           age_d[d_set][w] = age_q[d_set][w] - 1'b1;
                        end
                     end
                  end
               end
               count_d = count_q + enq_n - CNT_W'(drain);
            end
         end
         S_FLUSH: begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_d[fcnt_q][w] = 1'b0;
               age_d[fcnt_q][w]   = '0;
            end
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == SET_W'(NUM_SETS-1))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lookups read the post-write array so the entry drained this cycle is visible
   always_comb begin
      rd_hits    = '0;
      rd_targets = '0;
      if (state_q == S_IDLE) begin
         for (int r = 0; r < N_RD; r++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (valid_d[pc_set(rd_PCs[r*ADDR_BITS +: ADDR_BITS])][w] &&
                   (tag_d[pc_set(rd_PCs[r*ADDR_BITS +: ADDR_BITS])][w] ==
                    pc_tag(rd_PCs[r*ADDR_BITS +: ADDR_BITS]))) begin
                  rd_hits[r] = 1'b1;
                  rd_targets[r*ADDR_BITS +: ADDR_BITS] = rd_targets[r*ADDR_BITS +: ADDR_BITS] |
                     tgt_d[pc_set(rd_PCs[r*ADDR_BITS +: ADDR_BITS])][w];
               end
            end
         end
      end
   end

   // State registers; reset clears the whole table and queue at once
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         fcnt_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               tag_q[s][w]   <= '0;
               tgt_q[s][w]   <= '0;
               age_q[s][w]   <= '0;
            end
         end
         for (int i = 0; i < UPD_DEPTH; i++) begin
            qpc_q[i]  <= '0;
            qtgt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         age_q   <= age_d;
         qpc_q   <= qpc_d;
         qtgt_q  <= qtgt_d;
      end
   end

endmodule

// File: tb/tb_btb_assoc_queued.sv
// Directed bench for btb_assoc_queued: lookup/bypass, LRU fill and eviction,
// queue back-pressure and ordering, flush sequencing and reset mid-flush.
module tb_btb_assoc_queued;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] rd_PCs;
   logic [63:0] rd_targets;
   logic [1:0]  rd_hits;
   logic [1:0]  upd_valid;
   logic [63:0] upd_branch_PC;
   logic [63:0] upd_target_PC;
   logic        upd_ready;
   logic        flush_req;
   logic        flush_busy;
   logic        dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   btb_assoc_queued dut (
      .clock         (clock),
      .reset         (reset),
      .rd_PCs        (rd_PCs),
      .rd_targets    (rd_targets),
      .rd_hits       (rd_hits),
      .upd_valid     (upd_valid),
      .upd_branch_PC (upd_branch_PC),
      .upd_target_PC (upd_target_PC),
      .upd_ready     (upd_ready),
      .flush_req     (flush_req),
      .flush_busy    (flush_busy),
      .dbg_state     (dbg_state)
   );

   // clock
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // one lookup on a port, checked mid-cycle, then advance one cycle
   task automatic look(input int port, input logic [31:0] pc, input logic exp_hit,
                       input logic [31:0] exp_tgt, input string tag);
      rd_PCs[port*32 +: 32] = pc;
      #1;
      chk({tag, "_hit"}, {31'd0, rd_hits[port]}, {31'd0, exp_hit});
      chk({tag, "_tgt"}, rd_targets[port*32 +: 32], exp_tgt);
      tick();
   endtask

   // single update on lane 0 for one cycle
   task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt);
      upd_valid           = 2'b01;
      upd_branch_PC[31:0] = pc;
      upd_target_PC[31:0] = tgt;
      tick();
      upd_valid           = 2'b00;
   endtask

   initial begin
      reset         = 1'b0;
      rd_PCs        = '0;
      upd_valid     = '0;
      upd_branch_PC = '0;
      upd_target_PC = '0;
      flush_req     = 1'b0;
      #3;
      chk("rst_hits", {30'd0, rd_hits}, 32'd0);
      chk("rst_tgts", rd_targets[31:0] | rd_targets[63:32], 32'd0);
      chk("rst_ready", {31'd0, upd_ready}, 32'd1);
      chk("rst_busy", {31'd0, flush_busy}, 32'd0);
      #10 reset = 1'b1;
      tick();

      // 1: lookup on empty table
      chk("t1_ready", {31'd0, upd_ready}, 32'd1);
      look(0, 32'h100, 1'b0, 32'h0, "t1_miss");

      // 2: single update, bypass in the drain cycle
      rd_PCs[31:0]        = 32'h100;
      upd_valid           = 2'b01;
      upd_branch_PC[31:0] = 32'h100;
      upd_target_PC[31:0] = 32'h240;
      #1;
      chk("t2_pre_hit", {31'd0, rd_hits[0]}, 32'd0);
      tick();
      upd_valid     = 2'b00;
      rd_PCs[63:32] = 32'h104;
      #1;
      chk("t2_byp_hit", {31'd0, rd_hits[0]}, 32'd1);
      chk("t2_byp_tgt", rd_targets[31:0], 32'h240);
      chk("t2_104_hit", {31'd0, rd_hits[1]}, 32'd0);
      chk("t2_104_tgt", rd_targets[63:32], 32'h0);
      tick();
      look(0, 32'h100, 1'b1, 32'h240, "t2_after");

      // 3: five distinct tags into set 2, first one evicted
      for (int n = 0; n < 5; n++) do_upd(32'h008 + 32'(n) * 32'h40, 32'h1000 + 32'(n));
      tick();
      chk("t3_age_w0", {30'd0, dut.age_q[2][0]}, 32'd3);
      chk("t3_age_w1", {30'd0, dut.age_q[2][1]}, 32'd0);
      chk("t3_age_w2", {30'd0, dut.age_q[2][2]}, 32'd1);
      chk("t3_age_w3", {30'd0, dut.age_q[2][3]}, 32'd2);
      look(0, 32'h008, 1'b0, 32'h0, "t3_t0");
      look(1, 32'h048, 1'b1, 32'h1001, "t3_t1");
      look(0, 32'h088, 1'b1, 32'h1002, "t3_t2");
      look(1, 32'h0C8, 1'b1, 32'h1003, "t3_t3");
      look(0, 32'h108, 1'b1, 32'h1004, "t3_t4");

      // 4: A,B,C,D in set 3, re-touch A, insert E -> B evicted
      do_upd(32'h00C, 32'h2000);
      do_upd(32'h04C, 32'h2001);
      do_upd(32'h08C, 32'h2002);
      do_upd(32'h0CC, 32'h2003);
      do_upd(32'h00C, 32'h2AAA);
      do_upd(32'h10C, 32'h2004);
      tick();
      look(0, 32'h00C, 1'b1, 32'h2AAA, "t4_A");
      look(0, 32'h04C, 1'b0, 32'h0, "t4_B");
      look(1, 32'h08C, 1'b1, 32'h2002, "t4_C");
      look(1, 32'h0CC, 1'b1, 32'h2003, "t4_D");
      look(0, 32'h10C, 1'b1, 32'h2004, "t4_E");

      // 5: two lanes for three cycles into a 4-deep queue
      rd_PCs[31:0]  = 32'h014;
      upd_valid     = 2'b11;
      upd_branch_PC = {32'h054, 32'h014};
      upd_target_PC = {32'h501, 32'h500};
      #1;
      chk("t5_c0_ready", {31'd0, upd_ready}, 32'd1);
      chk("t5_c0_hit", {31'd0, rd_hits[0]}, 32'd0);
      tick();
      upd_branch_PC = {32'h094, 32'h014};
      upd_target_PC = {32'h503, 32'h502};
      #1;
      chk("t5_c1_ready", {31'd0, upd_ready}, 32'd1);
      chk("t5_c1_tgt", rd_targets[31:0], 32'h500);
      tick();
      upd_branch_PC = {32'h114, 32'h0D4};
      upd_target_PC = {32'h505, 32'h504};
      #1;
      chk("t5_c2_ready", {31'd0, upd_ready}, 32'd0);
      tick();
      upd_valid = 2'b00;
      #1;
      chk("t5_c3_ready", {31'd0, upd_ready}, 32'd1);
      chk("t5_c3_tgt", rd_targets[31:0], 32'h502);
      tick();
      tick();
      look(0, 32'h014, 1'b1, 32'h502, "t5_X");
      look(1, 32'h054, 1'b1, 32'h501, "t5_Y");
      look(0, 32'h094, 1'b1, 32'h503, "t5_Z");
      look(1, 32'h0D4, 1'b0, 32'h0, "t5_W");
      look(0, 32'h114, 1'b0, 32'h0, "t5_V");

      // lane 0 idle, lane 1 valid: only lane 1 is enqueued
      upd_valid     = 2'b10;
      upd_branch_PC = {32'h01C, 32'h05C};
      upd_target_PC = {32'h700, 32'h7FF};
      tick();
      upd_valid = 2'b00;
      look(0, 32'h01C, 1'b1, 32'h700, "t5_lane1");
      look(1, 32'h05C, 1'b0, 32'h0, "t5_lane0_idle");

      // 6: flush with updates queued and offered in the flush_req cycle
      upd_valid     = 2'b11;
      upd_branch_PC = {32'h058, 32'h018};
      upd_target_PC = {32'h601, 32'h600};
      tick();
      upd_valid           = 2'b01;
      upd_branch_PC[31:0] = 32'h098;
      upd_target_PC[31:0] = 32'h602;
      flush_req           = 1'b1;
      #1;
      chk("t6_req_busy", {31'd0, flush_busy}, 32'd0);
      tick();
      flush_req = 1'b0;
      upd_valid = 2'b00;
      rd_PCs    = {32'h00C, 32'h014};
      for (int i = 0; i < 16; i++) begin
         flush_req = (i == 8);
         #1;
         chk($sformatf("t6_busy_%0d", i), {31'd0, flush_busy}, 32'd1);
         chk($sformatf("t6_hits_%0d", i), {30'd0, rd_hits}, 32'd0);
         chk($sformatf("t6_tgt_%0d", i), rd_targets[31:0], 32'd0);
         chk($sformatf("t6_ready_%0d", i), {31'd0, upd_ready}, 32'd0);
         chk($sformatf("t6_dbg_%0d", i), {31'd0, dbg_state}, 32'd1);
         tick();
      end
      flush_req = 1'b0;
      #1;
      chk("t6_done_busy", {31'd0, flush_busy}, 32'd0);
      chk("t6_done_ready", {31'd0, upd_ready}, 32'd1);
      tick();
      look(0, 32'h014, 1'b0, 32'h0, "t6_X");
      look(1, 32'h00C, 1'b0, 32'h0, "t6_A");
      look(0, 32'h100, 1'b0, 32'h0, "t6_100");
      look(1, 32'h018, 1'b0, 32'h0, "t6_R");
      look(0, 32'h058, 1'b0, 32'h0, "t6_S");
      look(1, 32'h098, 1'b0, 32'h0, "t6_U");

      // table usable again, then reset in the middle of a flush
      do_upd(32'h014, 32'h900);
      look(0, 32'h014, 1'b1, 32'h900, "t6_refill");
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      repeat (5) tick();
      chk("t6_mid_busy", {31'd0, flush_busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_rst_busy", {31'd0, flush_busy}, 32'd0);
      chk("t6_rst_ready", {31'd0, upd_ready}, 32'd1);
      chk("t6_rst_hits", {30'd0, rd_hits}, 32'd0);
      #2 reset = 1'b1;
      tick();
      look(0, 32'h014, 1'b0, 32'h0, "t6_post_rst");
      chk("t6_post_busy", {31'd0, flush_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
